// File: rtl/wb_pipe_pkg.sv
// Shared types for the write-back pipeline stage: FSM state encoding and the
// payload record carried from the memory stage to register write-back.
package wb_pipe_pkg;

    localparam int WB_DATA_W = 32;
    localparam int WB_DEST_W = 4;

    // Encoding equals the number of held entries.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } wb_state_e;

    typedef struct packed {
        logic                 wb_en;
        logic                 mem_r_en;
        logic [WB_DATA_W-1:0] alu_result;
        logic [WB_DATA_W-1:0] mem_read_value;
        logic [WB_DEST_W-1:0] dest;
    } wb_payload_t;

    function automatic logic [1:0] state_occupancy(input wb_state_e s);
        logic [1:0] occ;
        case (s)
            ST_ONE:  occ = 2'd1;
            ST_TWO:  occ = 2'd2;
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/wb_stage_skid_reg.sv
// Write-back pipeline register built as a two-entry skid buffer: the main
// register drives the outputs, the skid register catches one payload on stall.
module wb_stage_skid_reg
    import wb_pipe_pkg::*;
#(
    parameter int DATA_W = WB_DATA_W,
    parameter int DEST_W = WB_DEST_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_wb_en,
    input  logic              in_mem_r_en,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] in_mem_read_value,
    input  logic [DEST_W-1:0] in_dest,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_wb_en,
    output logic              out_mem_r_en,
    output logic [DATA_W-1:0] out_alu_result,
    output logic [DATA_W-1:0] out_mem_read_value,
    output logic [DEST_W-1:0] out_dest,
    output logic [DATA_W-1:0] out_wb_value,
    output logic [1:0]        occupancy
);

    // Handshake: a payload moves on any rising edge where valid && ready on
    // that side. in_ready is a flop so upstream never sees out_ready through
    // this stage; flush cancels any same-cycle input transfer.
    wb_state_e   state_q, state_next;
    wb_payload_t main_q, skid_q, in_payload;
    logic        in_ready_q;
    logic        in_fire, out_fire;

    assign in_fire  = in_valid & in_ready_q & ~flush;
    assign out_fire = out_valid & out_ready;

    always_comb begin
        in_payload                = '0;
        in_payload.wb_en          = in_wb_en;
        in_payload.mem_r_en       = in_mem_r_en;
        in_payload.alu_result     = in_alu_result;
        in_payload.mem_read_value = in_mem_read_value;
        in_payload.dest           = in_dest;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_next;
            in_ready_q <= (state_next != ST_TWO);
        end
    end

    always_comb begin
        state_next = state_q;
        if (flush) begin
            state_next = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: if (in_fire) state_next = ST_ONE;
                ST_ONE: begin
                    if (in_fire && !out_fire)      state_next = ST_TWO;
                    else if (!in_fire && out_fire) state_next = ST_EMPTY;
                end
                ST_TWO:   if (out_fire) state_next = ST_ONE;
                default:  state_next = ST_EMPTY;
            endcase
        end
    end

    // Payload registers keep their contents on flush so the data outputs
    // simply hold while the stage reports a bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_q <= '0;
            skid_q <= '0;
        end else if (!flush) begin
            case (state_q)
                ST_EMPTY: if (in_fire) main_q <= in_payload;
                ST_ONE: begin
                    if (in_fire && out_fire) main_q <= in_payload;
                    else if (in_fire)        skid_q <= in_payload;
                end
                ST_TWO:   if (out_fire) main_q <= skid_q;
                default: ;
            endcase
        end
    end

    always_comb begin
        out_valid          = (state_q != ST_EMPTY);
        occupancy          = state_occupancy(state_q);
        in_ready           = in_ready_q;
        out_wb_en          = main_q.wb_en & out_valid;
        out_mem_r_en       = main_q.mem_r_en & out_valid;
        out_alu_result     = main_q.alu_result;
        out_mem_read_value = main_q.mem_read_value;
        out_dest           = main_q.dest;
        out_wb_value       = main_q.mem_r_en ? main_q.mem_read_value : main_q.alu_result;
    end

endmodule
